// File: rtl/unified_mem_arbiter.sv
// Arbiter and sequencer for a single-port unified memory shared by the
// instruction-fetch and data-memory stages. One access is in flight at a time.
module unified_mem_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int MEM_LAT    = 1,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    input  logic              if_flush,
    output logic              if_ready,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ready,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              stall_if,
    output logic              stall_mem,
    output logic              busy
);

    localparam int CNT_W = $clog2(MEM_LAT + 1);
    localparam int STV_W = $clog2(STARVE_MAX + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_e;
    typedef enum logic {OWN_IF, OWN_D} owner_e;

    state_e            state_q;
    owner_e            owner_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [STV_W-1:0]  starve_q;
    logic              cancel_q;
    logic              we_q;
    logic              mem_en_q;
    logic              mem_we_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q;
    logic              if_ready_q;
    logic [DATA_W-1:0] if_rdata_q;
    logic              d_ready_q;
    logic [DATA_W-1:0] d_rdata_q;

    logic fetch_req;
    logic grant_data;
    logic grant_fetch;
    logic fetch_cancel;

    // A flushed fetch is invisible to arbitration; a starved fetch overrides data.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        fetch_req    = 1'b0;
        grant_data   = 1'b0;
        grant_fetch  = 1'b0;
        fetch_cancel = 1'b0;
        fetch_req    = if_req & ~if_flush;
        grant_data   = d_req & ~((starve_q == STV_W'(STARVE_MAX)) & fetch_req);
        grant_fetch  = fetch_req & ~grant_data;
        fetch_cancel = cancel_q | if_flush;
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            owner_q     <= OWN_IF;
            cnt_q       <= '0;
            starve_q    <= '0;
            cancel_q    <= 1'b0;
            we_q        <= 1'b0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_ready_q  <= 1'b0;
            if_rdata_q  <= '0;
            d_ready_q   <= 1'b0;
            d_rdata_q   <= '0;
        end else begin
            mem_en_q   <= 1'b0;
            mem_we_q   <= 1'b0;
            if_ready_q <= 1'b0;
            d_ready_q  <= 1'b0;
            if (state_q != IDLE && owner_q == OWN_IF && if_flush) begin
                cancel_q <= 1'b1;
            end
            case (state_q)
                IDLE: begin
                    if (grant_data) begin
                        owner_q     <= OWN_D;
                        we_q        <= d_we;
                        mem_en_q    <= 1'b1;
                        mem_we_q    <= d_we;
                        mem_addr_q  <= d_addr;
                        mem_wdata_q <= d_wdata;
                        state_q     <= ISSUE;
                        if (if_req && starve_q != STV_W'(STARVE_MAX)) begin
                            starve_q <= starve_q + STV_W'(1);
                        end
                    end else if (grant_fetch) begin
                        owner_q    <= OWN_IF;
                        we_q       <= 1'b0;
                        mem_en_q   <= 1'b1;
                        mem_addr_q <= if_addr;
                        starve_q   <= '0;
                        state_q    <= ISSUE;
                    end
                end
                ISSUE: begin
                    cnt_q   <= CNT_W'(MEM_LAT);
                    state_q <= WAIT;
                end
                WAIT: begin
                    cnt_q <= cnt_q - CNT_W'(1);
                    // Last WAIT cycle is the one in which mem_rdata is valid.
                    if (cnt_q == CNT_W'(1)) begin
                        state_q <= DONE;
                        if (owner_q == OWN_D) begin
                            d_ready_q <= 1'b1;
                            if (!we_q) begin
                                d_rdata_q <= mem_rdata;
                            end
                        end else if (!fetch_cancel) begin
                            if_ready_q <= 1'b1;
                            if_rdata_q <= mem_rdata;
                        end
                    end
                end
                DONE: begin
                    cancel_q <= 1'b0;
                    state_q  <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign if_ready  = if_ready_q;
    assign if_rdata  = if_rdata_q;
    assign d_ready   = d_ready_q;
    assign d_rdata   = d_rdata_q;
    assign stall_if  = if_req & ~if_ready_q;
    assign stall_mem = d_req & ~d_ready_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Directed bench for unified_mem_arbiter: one instance at MEM_LAT=1 for the
// arbitration scenarios and one at MEM_LAT=3 for the mid-access reset case.
module tb_unified_mem_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fails  = 0;

    function automatic logic [31:0] mem_val(input logic [31:0] a);
        return (a == 32'h10) ? 32'h2008_0005 : (a ^ 32'hA5A5_0000);
    endfunction

    // MEM_LAT=1 instance
    logic        rst, if_req, if_flush, d_req, d_we;
    logic [31:0] if_addr, d_addr, d_wdata, mem_rdata;
    logic        if_ready, d_ready, mem_en, mem_we, stall_if, stall_mem, busy;
    logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata;

    unified_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1), .STARVE_MAX(4)) u_lat1 (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
        .if_ready(if_ready), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ready(d_ready), .d_rdata(d_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .stall_if(stall_if), .stall_mem(stall_mem), .busy(busy)
    );

    // Memory model: data only valid in the single cycle MEM_LAT after mem_en.
    logic        v1 = 1'b0;
    logic [31:0] a1 = '0;
    always @(posedge clk) begin
        v1 <= mem_en;
        a1 <= mem_addr;
    end
    assign mem_rdata = v1 ? mem_val(a1) : 32'hBAD0_BAD0;

    // MEM_LAT=3 instance
    logic        rst3, if_req3;
    logic [31:0] if_addr3, mem_rdata3;
    logic        if_ready3, d_ready3, mem_en3, mem_we3, stall_if3, stall_mem3, busy3;
    logic [31:0] if_rdata3, d_rdata3, mem_addr3, mem_wdata3;
    logic        if_flush3 = 1'b0, d_req3 = 1'b0, d_we3 = 1'b0;
    logic [31:0] d_addr3 = '0, d_wdata3 = '0;

    unified_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(3), .STARVE_MAX(4)) u_lat3 (
        .clk(clk), .rst(rst3),
        .if_req(if_req3), .if_addr(if_addr3), .if_flush(if_flush3),
        .if_ready(if_ready3), .if_rdata(if_rdata3),
        .d_req(d_req3), .d_we(d_we3), .d_addr(d_addr3), .d_wdata(d_wdata3),
        .d_ready(d_ready3), .d_rdata(d_rdata3),
        .mem_en(mem_en3), .mem_we(mem_we3), .mem_addr(mem_addr3), .mem_wdata(mem_wdata3),
        .mem_rdata(mem_rdata3),
        .stall_if(stall_if3), .stall_mem(stall_mem3), .busy(busy3)
    );

    logic [2:0]  v3 = '0;
    logic [31:0] a3_0 = '0, a3_1 = '0, a3_2 = '0;
    always @(posedge clk) begin
        v3   <= {v3[1:0], mem_en3};
        a3_0 <= mem_addr3;
        a3_1 <= a3_0;
        a3_2 <= a3_1;
    end
    assign mem_rdata3 = v3[2] ? mem_val(a3_2) : 32'hBAD0_BAD0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    logic [31:0] grants[$];
    logic [31:0] exp_g[6];
    logic [31:0] g;

    initial begin
        rst = 1'b1; rst3 = 1'b1;
        if_req = 0; if_flush = 0; d_req = 0; d_we = 0;
        if_addr = '0; d_addr = '0; d_wdata = '0;
        if_req3 = 0; if_addr3 = '0;
        #2;
        // Reset state
        check("rst_if_ready", {31'b0, if_ready}, 32'h0);
        check("rst_d_ready", {31'b0, d_ready}, 32'h0);
        check("rst_if_rdata", if_rdata, 32'h0);
        check("rst_d_rdata", d_rdata, 32'h0);
        check("rst_mem_en", {31'b0, mem_en}, 32'h0);
        check("rst_mem_we", {31'b0, mem_we}, 32'h0);
        check("rst_mem_addr", mem_addr, 32'h0);
        check("rst_mem_wdata", mem_wdata, 32'h0);
        check("rst_busy", {31'b0, busy}, 32'h0);
        check("rst_stall_if", {31'b0, stall_if}, 32'h0);
        check("rst_stall_mem", {31'b0, stall_mem}, 32'h0);
        tick(); tick();
        rst = 1'b0; rst3 = 1'b0;
        tick();

        // Single fetch, MEM_LAT=1
        if_req = 1; if_addr = 32'h10; #1;
        check("t1_c0_stall_if", {31'b0, stall_if}, 32'h1);
        check("t1_c0_mem_en", {31'b0, mem_en}, 32'h0);
        tick();
        check("t1_c1_mem_en", {31'b0, mem_en}, 32'h1);
        check("t1_c1_mem_addr", mem_addr, 32'h10);
        check("t1_c1_mem_we", {31'b0, mem_we}, 32'h0);
        check("t1_c1_busy", {31'b0, busy}, 32'h1);
        tick();
        check("t1_c2_mem_en", {31'b0, mem_en}, 32'h0);
        check("t1_c2_if_ready", {31'b0, if_ready}, 32'h0);
        check("t1_c2_stall_if", {31'b0, stall_if}, 32'h1);
        tick();
        check("t1_c3_if_ready", {31'b0, if_ready}, 32'h1);
        check("t1_c3_if_rdata", if_rdata, 32'h2008_0005);
        check("t1_c3_stall_if", {31'b0, stall_if}, 32'h0);
        tick();
        if_req = 0; #1;
        check("t1_c4_if_ready", {31'b0, if_ready}, 32'h0);
        check("t1_c4_busy", {31'b0, busy}, 32'h0);

        // Simultaneous fetch and load: data first
        if_req = 1; if_addr = 32'h20; d_req = 1; d_we = 0; d_addr = 32'h40; #1;
        check("t2_stall_mem", {31'b0, stall_mem}, 32'h1);
        tick();
        check("t2_c1_mem_en", {31'b0, mem_en}, 32'h1);
        check("t2_c1_mem_addr", mem_addr, 32'h40);
        tick(); tick();
        check("t2_c3_d_ready", {31'b0, d_ready}, 32'h1);
        check("t2_c3_d_rdata", d_rdata, 32'hA5A5_0040);
        check("t2_c3_if_ready", {31'b0, if_ready}, 32'h0);
        check("t2_c3_stall_if", {31'b0, stall_if}, 32'h1);
        tick();
        d_req = 0; #1;
        check("t2_c4_busy", {31'b0, busy}, 32'h0);
        tick();
        check("t2_c5_mem_en", {31'b0, mem_en}, 32'h1);
        check("t2_c5_mem_addr", mem_addr, 32'h20);
        tick(); tick();
        check("t2_c7_if_ready", {31'b0, if_ready}, 32'h1);
        check("t2_c7_if_rdata", if_rdata, 32'hA5A5_0020);
        tick();
        if_req = 0; #1;

        // Starvation: four data grants, then fetch, then data again
        d_req = 1; d_we = 0; d_addr = 32'h100; if_req = 1; if_addr = 32'h200; #1;
        for (int c = 0; c < 60 && grants.size() < 6; c++) begin
            if (mem_en) grants.push_back(mem_addr);
            if (if_ready) if_addr = 32'h204;
            tick();
        end
        check("t3_grant_count", grants.size(), 32'd6);
        exp_g = '{32'h100, 32'h100, 32'h100, 32'h100, 32'h200, 32'h100};
        for (int i = 0; i < 6; i++) begin
            g = (i < grants.size()) ? grants[i] : 32'hFFFF_FFFF;
            check($sformatf("t3_grant%0d", i), g, exp_g[i]);
        end
        for (int c = 0; c < 20 && !d_ready; c++) tick();
        check("t3_last_d_ready", {31'b0, d_ready}, 32'h1);
        tick();
        d_req = 0; if_req = 0; #1;
        check("t3_busy", {31'b0, busy}, 32'h0);
        check("t3_d_rdata", d_rdata, 32'hA5A5_0100);
        check("t3_if_rdata", if_rdata, 32'hA5A5_0200);

        // Store
        d_req = 1; d_we = 1; d_addr = 32'h80; d_wdata = 32'hDEAD_BEEF; #1;
        check("t4_stall_mem", {31'b0, stall_mem}, 32'h1);
        tick();
        check("t4_c1_mem_en", {31'b0, mem_en}, 32'h1);
        check("t4_c1_mem_we", {31'b0, mem_we}, 32'h1);
        check("t4_c1_mem_addr", mem_addr, 32'h80);
        check("t4_c1_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
        tick();
        check("t4_c2_mem_en", {31'b0, mem_en}, 32'h0);
        check("t4_c2_mem_we", {31'b0, mem_we}, 32'h0);
        tick();
        check("t4_c3_d_ready", {31'b0, d_ready}, 32'h1);
        check("t4_c3_d_rdata", d_rdata, 32'hA5A5_0100);
        tick();
        d_req = 0; d_we = 0; #1;
        check("t4_c4_d_ready", {31'b0, d_ready}, 32'h0);
        check("t4_c4_mem_wdata", mem_wdata, 32'hDEAD_BEEF);

        // Fetch flushed in WAIT, then flush in IDLE, then a normal fetch
        if_req = 1; if_addr = 32'h300; #1;
        tick();
        check("t5_c1_mem_addr", mem_addr, 32'h300);
        tick();
        if_flush = 1; #1;
        tick();
        if_flush = 0; #1;
        check("t5_c3_if_ready", {31'b0, if_ready}, 32'h0);
        check("t5_c3_busy", {31'b0, busy}, 32'h1);
        check("t5_c3_stall_if", {31'b0, stall_if}, 32'h1);
        check("t5_c3_if_rdata", if_rdata, 32'hA5A5_0200);
        tick();
        if_addr = 32'h400; if_flush = 1; #1;
        check("t5_c4_busy", {31'b0, busy}, 32'h0);
        check("t5_c4_if_ready", {31'b0, if_ready}, 32'h0);
        tick();
        if_flush = 0; #1;
        check("t5_c5_busy", {31'b0, busy}, 32'h0);
        check("t5_c5_mem_en", {31'b0, mem_en}, 32'h0);
        tick();
        check("t5_c6_mem_en", {31'b0, mem_en}, 32'h1);
        check("t5_c6_mem_addr", mem_addr, 32'h400);
        tick(); tick();
        check("t5_c8_if_ready", {31'b0, if_ready}, 32'h1);
        check("t5_c8_if_rdata", if_rdata, 32'hA5A5_0400);
        tick();
        if_req = 0; #1;

        // MEM_LAT=3: normal fetch completes in 5 cycles
        if_req3 = 1; if_addr3 = 32'h10; #1;
        for (int k = 1; k <= 5; k++) begin
            tick();
            if (k == 1) check("t6a_mem_en", {31'b0, mem_en3}, 32'h1);
            if (k == 4) check("t6a_early_ready", {31'b0, if_ready3}, 32'h0);
        end
        check("t6a_if_ready", {31'b0, if_ready3}, 32'h1);
        check("t6a_if_rdata", if_rdata3, 32'h2008_0005);
        tick();
        if_req3 = 0; #1;

        // MEM_LAT=3: reset in WAIT abandons the access
        if_req3 = 1; if_addr3 = 32'h40; #1;
        tick();
        check("t6b_mem_en", {31'b0, mem_en3}, 32'h1);
        tick(); tick();
        rst3 = 1; if_req3 = 0; #1;
        check("t6b_rst_busy", {31'b0, busy3}, 32'h0);
        check("t6b_rst_mem_en", {31'b0, mem_en3}, 32'h0);
        check("t6b_rst_mem_addr", mem_addr3, 32'h0);
        check("t6b_rst_if_rdata", if_rdata3, 32'h0);
        check("t6b_rst_if_ready", {31'b0, if_ready3}, 32'h0);
        check("t6b_rst_stall_if", {31'b0, stall_if3}, 32'h0);
        for (int k = 0; k < 3; k++) begin
            tick();
            check($sformatf("t6b_hold%0d_if_ready", k), {31'b0, if_ready3}, 32'h0);
        end
        rst3 = 0;
        tick();
        check("t6b_post_if_ready", {31'b0, if_ready3}, 32'h0);

        // Fresh request after reset
        if_req3 = 1; if_addr3 = 32'h100; #1;
        for (int k = 1; k <= 5; k++) begin
            tick();
            if (k == 4) check("t6c_early_ready", {31'b0, if_ready3}, 32'h0);
        end
        check("t6c_if_ready", {31'b0, if_ready3}, 32'h1);
        check("t6c_if_rdata", if_rdata3, 32'hA5A5_0100);
        tick();
        if_req3 = 0; #1;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/unified_mem_arbiter.md
Name: unified_mem_arbiter

Overview:
- Sequences a single-port unified memory shared by the pipeline's instruction-fetch stage and data-memory stage.
- Arbitrates between the two requesters and issues one memory command at a time.
- Waits out the fixed memory read latency, then returns data with a one-cycle ready pulse.
- Generates per-stage stall signals that the pipeline hazard logic ORs into its stall controls.

Parameters:
ADDR_W, 32, address width of both requesters and memory port
DATA_W, 32, data width
MEM_LAT, 1, cycles from mem_en to valid mem_rdata (legal >=1)
STARVE_MAX, 4, consecutive data grants with a fetch pending before fetch is forced (legal >=1)

Ports:
clk  in  1  clock; all state updates on the rising edge
rst  in  1  reset, asynchronous, active-high
if_req  in  1  fetch request; held high until if_ready
if_addr  in  ADDR_W  fetch address; stable while if_req is high
if_flush  in  1  cancels the outstanding fetch (branch/jump redirect)
if_ready  out  1  one-cycle pulse: if_rdata valid
if_rdata  out  DATA_W  fetched instruction
d_req  in  1  data request; held high until d_ready
d_we  in  1  1 = store, 0 = load; stable while d_req is high
d_addr  in  ADDR_W  data address
d_wdata  in  DATA_W  store data
d_ready  out  1  one-cycle pulse: access complete
d_rdata  out  DATA_W  load data
mem_en  out  1  memory command strobe, exactly one cycle per access
mem_we  out  1  memory write enable, qualified by mem_en
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_rdata  in  DATA_W  memory read data, valid MEM_LAT cycles after mem_en
stall_if  out  1  if_req & ~if_ready (combinational)
stall_mem  out  1  d_req & ~d_ready (combinational)
busy  out  1  state != IDLE

Behaviour:
- Reset: state IDLE; all outputs 0 (if_rdata and d_rdata included); owner, latency counter, starve counter and cancel flag cleared. Reset asserted mid-access abandons the access; no ready is issued.
- Memory command outputs (mem_en, mem_we, mem_addr, mem_wdata) are registered. mem_en/mem_we are 0 outside ISSUE; mem_addr/mem_wdata hold their last values.
- States:
  - IDLE: if d_req or if_req is high at the edge, latch owner and command, then go to ISSUE.
  - ISSUE: one cycle, mem_en=1. Next state is WAIT, with the counter loaded to MEM_LAT.
  - WAIT: counter decrements each cycle. At the edge ending the cycle in which mem_rdata is valid (cycle ISSUE+MEM_LAT), capture mem_rdata into the owner's rdata register (loads and fetches only), then go to DONE.
  - DONE: one cycle; the owner's ready = 1 (unless cancelled). Next state is IDLE.
- Latency: request seen in IDLE in cycle t -> mem_en in t+1 -> ready in t+2+MEM_LAT. Stores use the same timing. d_rdata is unchanged by stores.
- Requests are sampled only in IDLE. A request still high in the IDLE cycle after DONE is treated as a new request. Back-to-back throughput is one access per MEM_LAT+3 cycles.
- Priority: d_req beats if_req, except when starve_cnt == STARVE_MAX and if_req is high, in which case fetch wins.
- starve_cnt increments (saturating at STARVE_MAX) on each data grant made while if_req is high. It clears on any fetch grant.
- if_flush:
  - Fetch owns the port (ISSUE/WAIT/DONE): set the cancel flag. The memory access completes, if_ready stays 0 in DONE, if_rdata is not updated, and the flag clears on return to IDLE.
  - Arbiter in IDLE: the fetch request is ignored that cycle.
  - No effect on a data access.
- Data accesses are never cancelled.
- The owner is fixed from ISSUE through DONE. Requester input changes during that window are ignored; the latched command is used.
- stall_if/stall_mem are purely combinational from req and ready. A cancelled fetch keeps stall_if high until if_req drops.

Test Plan:
- MEM_LAT=1, if_req with if_addr=0x0000_0010 at cycle 0, memory returns 0x2008_0005 -> mem_en cycle 1 with mem_addr=0x10, if_ready=1 at cycle 3 with if_rdata=0x2008_0005, stall_if high during cycles 0-2.
- if_req and d_req (load, d_addr=0x40) both high in IDLE -> data served first (d_ready at t+3), then fetch issued (if_ready at t+7); owner order checked via mem_addr.
- STARVE_MAX=4, d_req held high continuously with if_req high -> after 4 data grants the 5th grant goes to fetch; starve_cnt returns to 0.
- Store d_we=1, d_addr=0x80, d_wdata=0xDEAD_BEEF -> single mem_en cycle with mem_we=1 and matching address/data; d_ready pulse at t+3; d_rdata unchanged.
- Fetch in WAIT, if_flush pulsed -> no if_ready, if_rdata unchanged, busy falls after DONE, next fetch completes normally.
- MEM_LAT=3, reset asserted during WAIT -> all outputs 0 immediately, no ready pulse, fresh request after reset completes in 5 cycles.
